// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU and a loader.
// Ports: CLK/RST (sync active-high), CPU_* and LD_* request/return, MEM_* memory side.
// Macro DMEM_ARB_STARVE_EN adds a loader starvation counter (limit STARVE_LIMIT).
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CPU_Req,
  input  logic        CPU_W_En,
  input  logic [2:0]  CPU_Control,
  input  logic [31:0] CPU_Addr,
  input  logic [31:0] CPU_W_Data,
  output logic        CPU_Stall,
  output logic        CPU_R_Valid,
  output logic [31:0] CPU_R_Data,
  input  logic        LD_Req,
  input  logic        LD_W_En,
  input  logic [2:0]  LD_Control,
  input  logic [31:0] LD_Addr,
  input  logic [31:0] LD_W_Data,
  output logic        LD_Gnt,
  output logic        LD_R_Valid,
  output logic [31:0] LD_R_Data,
  output logic        MEM_W_En,
  output logic [2:0]  MEM_Control,
  output logic [31:0] RW_Addr,
  output logic [31:0] W_Data,
  input  logic [31:0] R_Data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_CPU = 2'd1,
    RD_LD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] addr_q, addr_d;

  logic idle;
  logic force_ld;
  logic cpu_win;
  logic ld_win;
  logic mem_we;
  logic rd_cpu;
  logic rd_ld;

  assign idle = (state_q == IDLE);

`ifdef DMEM_ARB_STARVE_EN
  localparam int unsigned CW =
    (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Loader has waited long enough: it wins the next idle cycle.
  assign force_ld = (cnt_q == CW'(STARVE_LIMIT));
`else
  assign force_ld = 1'b0;
`endif

  // Force only matters if the loader is actually asking.
  assign cpu_win = idle & CPU_Req & ~(force_ld & LD_Req);
  assign ld_win  = idle & LD_Req & ~cpu_win;

  // Memory-side mux.
  always_comb begin
    MEM_Control = CPU_Control;
    RW_Addr     = CPU_Addr;
    W_Data      = CPU_W_Data;
    mem_we      = 1'b0;
    unique case (1'b1)
      !idle: begin
        MEM_Control = ctrl_q;
        RW_Addr     = addr_q;
        W_Data      = 32'h0;
      end
      ld_win: begin
        MEM_Control = LD_Control;
        RW_Addr     = LD_Addr;
        W_Data      = LD_W_Data;
        mem_we      = LD_W_En;
      end
      default: begin
        mem_we = cpu_win & CPU_W_En;
      end
    endcase
  end

  // Next state and read latch.
  always_comb begin
    state_d = IDLE;
    ctrl_d  = ctrl_q;
    addr_d  = addr_q;
    if (cpu_win && !CPU_W_En) begin
      state_d = RD_CPU;
      ctrl_d  = CPU_Control;
      addr_d  = CPU_Addr;
    end else if (ld_win && !LD_W_En) begin
      state_d = RD_LD;
      ctrl_d  = LD_Control;
      addr_d  = LD_Addr;
    end
  end

`ifdef DMEM_ARB_STARVE_EN
  always_comb begin
    cnt_d = cnt_q;
    if (ld_win) begin
      cnt_d = '0;
    end else if (idle && LD_Req &&
                 cnt_q < CW'(STARVE_LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ctrl_q  <= 3'b000;
      addr_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      addr_q  <= addr_d;
    end
  end

  // Reset masks every strobe, so a read in flight is dropped.
  assign rd_cpu = (state_q == RD_CPU) & ~RST;
  assign rd_ld  = (state_q == RD_LD) & ~RST;

  assign MEM_W_En    = mem_we & ~RST;
  assign LD_Gnt      = ld_win & ~RST;
  assign CPU_R_Valid = rd_cpu;
  assign CPU_R_Data  = rd_cpu ? R_Data : 32'h0;
  assign LD_R_Valid  = rd_ld;
  assign LD_R_Data   = rd_ld ? R_Data : 32'h0;

  assign CPU_Stall = CPU_Req &
    ~((cpu_win & CPU_W_En) | (state_q == RD_CPU));

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter.
// Byte-addressed memory model with RISC-V style load extension.
module tb_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CPU_Req, CPU_W_En;
  logic [2:0]  CPU_Control;
  logic [31:0] CPU_Addr, CPU_W_Data;
  logic        CPU_Stall, CPU_R_Valid;
  logic [31:0] CPU_R_Data;
  logic        LD_Req, LD_W_En;
  logic [2:0]  LD_Control;
  logic [31:0] LD_Addr, LD_W_Data;
  logic        LD_Gnt, LD_R_Valid;
  logic [31:0] LD_R_Data;
  logic        MEM_W_En;
  logic [2:0]  MEM_Control;
  logic [31:0] RW_Addr, W_Data, R_Data;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  dmem_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RST(RST),
    .CPU_Req(CPU_Req), .CPU_W_En(CPU_W_En),
    .CPU_Control(CPU_Control), .CPU_Addr(CPU_Addr),
    .CPU_W_Data(CPU_W_Data), .CPU_Stall(CPU_Stall),
    .CPU_R_Valid(CPU_R_Valid), .CPU_R_Data(CPU_R_Data),
    .LD_Req(LD_Req), .LD_W_En(LD_W_En),
    .LD_Control(LD_Control), .LD_Addr(LD_Addr),
    .LD_W_Data(LD_W_Data), .LD_Gnt(LD_Gnt),
    .LD_R_Valid(LD_R_Valid), .LD_R_Data(LD_R_Data),
    .MEM_W_En(MEM_W_En), .MEM_Control(MEM_Control),
    .RW_Addr(RW_Addr), .W_Data(W_Data), .R_Data(R_Data)
  );

  logic [7:0] mem [0:255];
  logic [7:0] ma;
  logic [31:0] mw;

  always @(posedge CLK) begin
    if (MEM_W_En) begin
      mem[RW_Addr[7:0]] = W_Data[7:0];
      if (MEM_Control[1:0] != 2'b00)
        mem[RW_Addr[7:0] + 8'd1] = W_Data[15:8];
      if (MEM_Control[1:0] == 2'b10) begin
        mem[RW_Addr[7:0] + 8'd2] = W_Data[23:16];
        mem[RW_Addr[7:0] + 8'd3] = W_Data[31:24];
      end
    end
  end

  always @* begin
    ma = RW_Addr[7:0];
    mw = {mem[ma + 8'd3], mem[ma + 8'd2],
          mem[ma + 8'd1], mem[ma]};
    case (MEM_Control)
      3'b000:  R_Data = {{24{mw[7]}}, mw[7:0]};
      3'b001:  R_Data = {{16{mw[15]}}, mw[15:0]};
      3'b100:  R_Data = {24'h0, mw[7:0]};
      3'b101:  R_Data = {16'h0, mw[15:0]};
      default: R_Data = mw;
    endcase
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    CPU_Req = 1'b1; CPU_W_En = 1'b1; CPU_Control = 3'b010;
    CPU_Addr = 32'h10; CPU_W_Data = 32'h1111_1111;
    LD_Req = 1'b1; LD_W_En = 1'b1;
    #1;
    tests++; if (MEM_W_En !== 1'b0) begin fails++; $display("FAIL rst_we got=%b exp=0", MEM_W_En); end
    tests++; if (LD_Gnt !== 1'b0) begin fails++; $display("FAIL rst_gnt got=%b exp=0", LD_Gnt); end
    tests++; if (CPU_R_Valid !== 1'b0 || LD_R_Valid !== 1'b0) begin fails++; $display("FAIL rst_valid got=%b%b exp=00", CPU_R_Valid, LD_R_Valid); end
    tests++; if (CPU_R_Data !== 32'h0 || LD_R_Data !== 32'h0) begin fails++; $display("FAIL rst_rdata got=%h/%h exp=0", CPU_R_Data, LD_R_Data); end
    tick();
    RST = 1'b0; CPU_Req = 1'b0; LD_Req = 1'b0;
    CPU_W_En = 1'b0; LD_W_En = 1'b0;
    #1;
    tests++; if (MEM_W_En !== 1'b0 || LD_Gnt !== 1'b0) begin fails++; $display("FAIL post_rst got=%b%b exp=00", MEM_W_En, LD_Gnt); end
    tests++; if (CPU_R_Valid !== 1'b0 || CPU_R_Data !== 32'h0) begin fails++; $display("FAIL post_rst_rd got=%b/%h exp=0/0", CPU_R_Valid, CPU_R_Data); end
    tests++; if (CPU_Stall !== 1'b0) begin fails++; $display("FAIL post_rst_stall got=%b exp=0", CPU_Stall); end
    tick();
  endtask

  task automatic test_cpu_write_read();
    CPU_Req = 1'b1; CPU_W_En = 1'b1; CPU_Control = 3'b010;
    CPU_Addr = 32'h10; CPU_W_Data = 32'hDEADBEEF;
    #1;
    tests++; if (MEM_W_En !== 1'b1) begin fails++; $display("FAIL wr_we got=%b exp=1", MEM_W_En); end
    tests++; if (CPU_Stall !== 1'b0) begin fails++; $display("FAIL wr_stall got=%b exp=0", CPU_Stall); end
    tests++; if (RW_Addr !== 32'h10 || W_Data !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_bus got=%h/%h exp=10/deadbeef", RW_Addr, W_Data); end
    tick();
    CPU_Req = 1'b0; CPU_W_En = 1'b0; CPU_Addr = 32'h54;
    #1;
    tests++; if (MEM_W_En !== 1'b0 || RW_Addr !== 32'h54) begin fails++; $display("FAIL idle_pass got=%b/%h exp=0/54", MEM_W_En, RW_Addr); end
    tick();
    CPU_Req = 1'b1; CPU_Addr = 32'h10;
    #1;
    tests++; if (CPU_Stall !== 1'b1 || CPU_R_Valid !== 1'b0) begin fails++; $display("FAIL rd_c1 got=%b%b exp=10", CPU_Stall, CPU_R_Valid); end
    tests++; if (MEM_W_En !== 1'b0) begin fails++; $display("FAIL rd_c1_we got=%b exp=0", MEM_W_En); end
    tick();
    #1;
    tests++; if (CPU_R_Valid !== 1'b1 || CPU_Stall !== 1'b0) begin fails++; $display("FAIL rd_c2 got=%b%b exp=10", CPU_R_Valid, CPU_Stall); end
    tests++; if (CPU_R_Data !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data got=%h exp=deadbeef", CPU_R_Data); end
    tests++; if (W_Data !== 32'h0 || MEM_W_En !== 1'b0) begin fails++; $display("FAIL rd_c2_bus got=%h/%b exp=0/0", W_Data, MEM_W_En); end
    tick();
    CPU_Req = 1'b0;
    #1;
    tests++; if (CPU_R_Valid !== 1'b0 || CPU_R_Data !== 32'h0) begin fails++; $display("FAIL rd_done got=%b/%h exp=0/0", CPU_R_Valid, CPU_R_Data); end
    tick();
  endtask

  task automatic test_loader_read();
    LD_Req = 1'b1; LD_W_En = 1'b1; LD_Control = 3'b010;
    LD_Addr = 32'h20; LD_W_Data = 32'h12345678;
    #1;
    tests++; if (LD_Gnt !== 1'b1 || MEM_W_En !== 1'b1) begin fails++; $display("FAIL ldwr got=%b%b exp=11", LD_Gnt, MEM_W_En); end
    tests++; if (W_Data !== 32'h12345678 || RW_Addr !== 32'h20) begin fails++; $display("FAIL ldwr_bus got=%h/%h exp=12345678/20", W_Data, RW_Addr); end
    tick();
    LD_W_En = 1'b0;
    #1;
    tests++; if (LD_Gnt !== 1'b1 || MEM_W_En !== 1'b0) begin fails++; $display("FAIL ldrd_c1 got=%b%b exp=10", LD_Gnt, MEM_W_En); end
    tick();
    LD_Req = 1'b0;
    CPU_Req = 1'b1; CPU_W_En = 1'b0; CPU_Control = 3'b010;
    CPU_Addr = 32'h10;
    #1;
    tests++; if (LD_R_Valid !== 1'b1 || LD_R_Data !== 32'h12345678) begin fails++; $display("FAIL ldrd_c2 got=%b/%h exp=1/12345678", LD_R_Valid, LD_R_Data); end
    tests++; if (CPU_Stall !== 1'b1 || LD_Gnt !== 1'b0) begin fails++; $display("FAIL ldrd_cpu got=%b%b exp=10", CPU_Stall, LD_Gnt); end
    tests++; if (RW_Addr !== 32'h20 || CPU_R_Valid !== 1'b0) begin fails++; $display("FAIL ldrd_addr got=%h/%b exp=20/0", RW_Addr, CPU_R_Valid); end
    tick();
    #1;
    tests++; if (RW_Addr !== 32'h10 || LD_R_Valid !== 1'b0) begin fails++; $display("FAIL cpu_after got=%h/%b exp=10/0", RW_Addr, LD_R_Valid); end
    tests++; if (LD_R_Data !== 32'h0) begin fails++; $display("FAIL ld_rdata_idle got=%h exp=0", LD_R_Data); end
    tick();
    #1;
    tests++; if (CPU_R_Valid !== 1'b1 || CPU_R_Data !== 32'hDEADBEEF) begin fails++; $display("FAIL cpu_after_rd got=%b/%h exp=1/deadbeef", CPU_R_Valid, CPU_R_Data); end
    tick();
    CPU_Req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    CPU_Req = 1'b1; CPU_W_En = 1'b0; CPU_Control = 3'b010;
    CPU_Addr = 32'h10;
    #1;
    tests++; if (CPU_Stall !== 1'b1 || CPU_R_Valid !== 1'b0) begin fails++; $display("FAIL b2b_c1 got=%b%b exp=10", CPU_Stall, CPU_R_Valid); end
    tick();
    #1;
    tests++; if (CPU_R_Valid !== 1'b1 || CPU_R_Data !== 32'hDEADBEEF) begin fails++; $display("FAIL b2b_c2 got=%b/%h exp=1/deadbeef", CPU_R_Valid, CPU_R_Data); end
    tick();
    CPU_Addr = 32'h20;
    #1;
    tests++; if (CPU_Stall !== 1'b1 || RW_Addr !== 32'h20) begin fails++; $display("FAIL b2b_c3 got=%b/%h exp=1/20", CPU_Stall, RW_Addr); end
    tick();
    #1;
    tests++; if (CPU_R_Valid !== 1'b1 || CPU_R_Data !== 32'h12345678) begin fails++; $display("FAIL b2b_c4 got=%b/%h exp=1/12345678", CPU_R_Valid, CPU_R_Data); end
    tick();
    CPU_Req = 1'b0;
    tick();
  endtask

  task automatic test_signed_byte();
    CPU_Req = 1'b1; CPU_W_En = 1'b1; CPU_Control = 3'b000;
    CPU_Addr = 32'h13; CPU_W_Data = 32'h0000_0080;
    #1;
    tests++; if (MEM_W_En !== 1'b1 || MEM_Control !== 3'b000) begin fails++; $display("FAIL sb got=%b/%b exp=1/000", MEM_W_En, MEM_Control); end
    tick();
    CPU_W_En = 1'b0;
    #1;
    tests++; if (RW_Addr !== 32'h13 || MEM_Control !== 3'b000 || CPU_Stall !== 1'b1) begin fails++; $display("FAIL lb_c1 got=%h/%b/%b exp=13/000/1", RW_Addr, MEM_Control, CPU_Stall); end
    tick();
    #1;
    tests++; if (RW_Addr !== 32'h13 || MEM_Control !== 3'b000) begin fails++; $display("FAIL lb_c2 got=%h/%b exp=13/000", RW_Addr, MEM_Control); end
    tests++; if (CPU_R_Data !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_data got=%h exp=ffffff80", CPU_R_Data); end
    tick();
    CPU_Control = 3'b100;
    #1;
    tests++; if (CPU_Stall !== 1'b1) begin fails++; $display("FAIL lbu_c1 got=%b exp=1", CPU_Stall); end
    tick();
    #1;
    tests++; if (CPU_R_Data !== 32'h00000080 || MEM_Control !== 3'b100) begin fails++; $display("FAIL lbu_data got=%h/%b exp=80/100", CPU_R_Data, MEM_Control); end
    tick();
    CPU_Req = 1'b0;
    tick();
  endtask

  task automatic test_priority();
    logic exp_g;
    CPU_Req = 1'b1; CPU_W_En = 1'b1; CPU_Control = 3'b010;
    CPU_Addr = 32'h40; CPU_W_Data = 32'hC0C0C0C0;
    LD_Req = 1'b1; LD_W_En = 1'b1; LD_Control = 3'b010;
    LD_Addr = 32'h44; LD_W_Data = 32'h1D1D1D1D;
    for (int i = 0; i < 20; i++) begin
`ifdef DMEM_ARB_STARVE_EN
      exp_g = ((i % 5) == 4);
`else
      exp_g = 1'b0;
`endif
      #1;
      tests++; if (LD_Gnt !== exp_g || CPU_Stall !== exp_g) begin fails++; $display("FAIL prio cyc=%0d gnt/stall got=%b%b exp=%b%b", i, LD_Gnt, CPU_Stall, exp_g, exp_g); end
      tests++; if (MEM_W_En !== 1'b1 || RW_Addr !== (exp_g ? 32'h44 : 32'h40)) begin fails++; $display("FAIL prio_bus cyc=%0d got=%b/%h exp=1/%h", i, MEM_W_En, RW_Addr, exp_g ? 32'h44 : 32'h40); end
      tick();
    end
    CPU_Req = 1'b0; CPU_W_En = 1'b0;
    LD_Req = 1'b0; LD_W_En = 1'b0;
    tick();
  endtask

  task automatic test_reset_abort();
    CPU_Req = 1'b1; CPU_W_En = 1'b0; CPU_Control = 3'b010;
    CPU_Addr = 32'h20;
    #1;
    tests++; if (CPU_Stall !== 1'b1) begin fails++; $display("FAIL abort_c1 got=%b exp=1", CPU_Stall); end
    tick();
    RST = 1'b1; CPU_Req = 1'b0;
    #1;
    tests++; if (CPU_R_Valid !== 1'b0 || CPU_R_Data !== 32'h0) begin fails++; $display("FAIL abort_rst got=%b/%h exp=0/0", CPU_R_Valid, CPU_R_Data); end
    tick();
    RST = 1'b0; CPU_Addr = 32'h99;
    #1;
    tests++; if (CPU_R_Valid !== 1'b0 || MEM_W_En !== 1'b0) begin fails++; $display("FAIL abort_after got=%b%b exp=00", CPU_R_Valid, MEM_W_En); end
    tests++; if (RW_Addr !== 32'h99 || W_Data !== CPU_W_Data) begin fails++; $display("FAIL abort_idle got=%h exp=99", RW_Addr); end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    RST = 1'b1;
    CPU_Req = 1'b0; CPU_W_En = 1'b0; CPU_Control = 3'b000;
    CPU_Addr = 32'h0; CPU_W_Data = 32'h0;
    LD_Req = 1'b0; LD_W_En = 1'b0; LD_Control = 3'b000;
    LD_Addr = 32'h0; LD_W_Data = 32'h0;
    tick();
    tick();
    test_reset();
    test_cpu_write_read();
    test_loader_read();
    test_back_to_back();
    test_signed_byte();
    test_priority();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
